// File: rtl/bomb_game_ctrl_pkg.sv
// Shared definitions for the bomb game: state encoding (also decoded by the LED driver),
// LFSR seed/taps and datapath widths.
package bomb_game_pkg;

    localparam int STATE_W  = 3;
    localparam int KEY_W    = 8;
    localparam int SEC_W    = 8;
    localparam int TARGET_W = 3;
    localparam int LFSR_W   = 16;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE       = 3'b000,
        ST_GAME_START = 3'b001,
        ST_GAME_CLEAR = 3'b010,
        ST_GAME_FAIL  = 3'b011
    } game_state_e;

    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 of a right-shifting Fibonacci register land on bits 0,2,3,5.
    localparam logic [LFSR_W-1:0] LFSR_TAP_MASK = 16'h002D;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {^(s & LFSR_TAP_MASK), s[LFSR_W-1:1]};
    endfunction

    function automatic logic [KEY_W-1:0] key_onehot(input logic [TARGET_W-1:0] idx);
        return KEY_W'(1) << idx;
    endfunction

endpackage

// File: rtl/bomb_game_ctrl_if.sv
// Player-facing signal bundle of the bomb game controller.
interface bomb_game_ctrl_if;
    import bomb_game_pkg::*;

    logic                 i_fStart;
    logic [KEY_W-1:0]     i_Key;
    logic [STATE_W-1:0]   o_State;
    logic                 o_Sec1Tick;
    logic [3:0]           o_Random4Bit;
    logic [SEC_W-1:0]     o_RemainSec;
    logic [SEC_W-1:0]     o_Score;

    modport slave (
        input  i_fStart, i_Key,
        output o_State, o_Sec1Tick, o_Random4Bit, o_RemainSec, o_Score
    );

    modport master (
        output i_fStart, i_Key,
        input  o_State, o_Sec1Tick, o_Random4Bit, o_RemainSec, o_Score
    );

endinterface

// File: rtl/bomb_game_ctrl_sec_tick_gen.sv
// One-second tick generator: wrapping counter with a registered single-cycle tick
// at terminal count; a synchronous clear restarts the second from zero.
module sec_tick_gen #(
    parameter int P_CLK_PER_SEC = 50_000_000
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (P_CLK_PER_SEC > 1) ? $clog2(P_CLK_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(P_CLK_PER_SEC - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (clr) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            tick  <= (count == CNT_MAX);
            count <= (count == CNT_MAX) ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/bomb_game_ctrl.sv
// Bomb game sequencer: game FSM, LFSR, key edge judging, countdown and score.
// state         | meaning
// ST_IDLE       | waiting for start; score=0, remain=P_GAME_SEC, no ticks
// ST_GAME_START | game running; judge key rises against lit LED, count down seconds
// ST_GAME_CLEAR | enough hits; hold result for P_RESULT_SEC seconds
// ST_GAME_FAIL  | wrong key or timeout; hold result for P_RESULT_SEC seconds
module bomb_game_ctrl
    import bomb_game_pkg::*;
#(
    parameter int P_CLK_PER_SEC = 50_000_000,
    parameter int P_GAME_SEC    = 30,
    parameter int P_HITS_TO_WIN = 10,
    parameter int P_RESULT_SEC  = 3
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    bomb_game_ctrl_if.slave   bus
);

    localparam logic [SEC_W-1:0] GAME_SEC    = P_GAME_SEC[SEC_W-1:0];
    localparam logic [SEC_W-1:0] HITS_TO_WIN = P_HITS_TO_WIN[SEC_W-1:0];
    localparam logic [SEC_W-1:0] RESULT_SEC  = P_RESULT_SEC[SEC_W-1:0];

    game_state_e          state;
    logic [LFSR_W-1:0]    lfsr;
    logic [KEY_W-1:0]     key_d;
    logic [TARGET_W-1:0]  target;
    logic                 consumed;
    logic [SEC_W-1:0]     remain;
    logic [SEC_W-1:0]     score;
    logic [SEC_W-1:0]     result_cnt;

    logic                 tick;
    logic                 tick_clr;
    logic [KEY_W-1:0]     rise;
    logic [KEY_W-1:0]     target_key;
    logic                 in_game;
    logic                 in_result;
    logic                 start;
    logic                 key_hit;
    logic                 key_wrong;
    logic                 win;
    logic                 timeout;
    logic                 result_done;

    assign rise        = bus.i_Key & ~key_d;
    assign target_key  = key_onehot(target);
    assign in_game     = (state == ST_GAME_START);
    assign in_result   = (state == ST_GAME_CLEAR) || (state == ST_GAME_FAIL);
    assign start       = (state == ST_IDLE) && bus.i_fStart;
    assign key_hit     = in_game && !consumed && (rise == target_key);
    assign key_wrong   = in_game && !consumed && (rise != '0) && (rise != target_key);
    assign win         = key_hit && ((score + SEC_W'(1)) == HITS_TO_WIN);
    assign timeout     = in_game && tick && (remain == SEC_W'(1));
    assign result_done = in_result && tick && (result_cnt == SEC_W'(1));

    // Every transition restarts the second so the first tick of a state lands a full second in.
    assign tick_clr = start || key_wrong || win || timeout || result_done
                      || !(in_game || in_result);

    sec_tick_gen #(
        .P_CLK_PER_SEC (P_CLK_PER_SEC)
    ) u_sec_tick_gen (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .clr   (tick_clr),
        .tick  (tick)
    );

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            lfsr  <= LFSR_SEED;
            key_d <= '0;
        end else begin
            lfsr  <= lfsr_next(lfsr);
            key_d <= bus.i_Key;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state      <= ST_IDLE;
            target     <= '0;
            consumed   <= 1'b0;
            remain     <= GAME_SEC;
            score      <= '0;
            result_cnt <= RESULT_SEC;
        end else begin
            case (state)
                ST_IDLE: begin
                    score  <= '0;
                    remain <= GAME_SEC;
                    if (bus.i_fStart) begin
                        state    <= ST_GAME_START;
                        target   <= lfsr[TARGET_W-1:0];
                        consumed <= 1'b0;
                    end
                end
                ST_GAME_START: begin
                    if (key_hit) begin
                        score    <= score + SEC_W'(1);
                        consumed <= 1'b1;
                    end
                    // A tick in the same cycle as a hit re-arms judging on the new LED.
                    if (tick) begin
                        remain   <= remain - SEC_W'(1);
                        target   <= lfsr[TARGET_W-1:0];
                        consumed <= 1'b0;
                    end
                    if (key_wrong) begin
                        state      <= ST_GAME_FAIL;
                        result_cnt <= RESULT_SEC;
                    end else if (win) begin
                        state      <= ST_GAME_CLEAR;
                        result_cnt <= RESULT_SEC;
                    end else if (timeout) begin
                        state      <= ST_GAME_FAIL;
                        result_cnt <= RESULT_SEC;
                    end
                end
                ST_GAME_CLEAR, ST_GAME_FAIL: begin
                    if (tick) begin
                        if (result_cnt == SEC_W'(1)) begin
                            state  <= ST_IDLE;
                            score  <= '0;
                            remain <= GAME_SEC;
                        end else begin
                            result_cnt <= result_cnt - SEC_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_State      = state;
    assign bus.o_Sec1Tick   = tick;
    assign bus.o_Random4Bit = lfsr[3:0];
    assign bus.o_RemainSec  = remain;
    assign bus.o_Score      = score;

endmodule

// File: tb/tb_bomb_game_ctrl.sv
// Scoreboard bench for bomb_game_ctrl: a cycle-level game model predicts every output,
// a monitor compares each cycle; reset values are also checked directly.
module tb_bomb_game_ctrl;

    localparam int TB_CPS = 10;
    localparam int TB_GS  = 3;
    localparam int TB_HW  = 2;
    localparam int TB_RS  = 2;

    logic i_Clk;
    logic i_Rst;

    bomb_game_ctrl_if bus ();

    bomb_game_ctrl #(
        .P_CLK_PER_SEC (TB_CPS),
        .P_GAME_SEC    (TB_GS),
        .P_HITS_TO_WIN (TB_HW),
        .P_RESULT_SEC  (TB_RS)
    ) dut (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .bus   (bus)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic [2:0] st;
        logic       tk;
        logic [3:0] rnd;
        logic [7:0] rem;
        logic [7:0] sc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Game model: states 0 idle, 1 playing, 2 clear, 3 fail; age = cycles since state entry.
    int          m_state, m_age, m_score, m_remain, m_res;
    logic [15:0] m_lfsr;
    logic [2:0]  m_target;
    bit          m_used;
    logic [7:0]  m_kprev;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_tick();
        return (m_state != 0) && (m_age > 0) && ((m_age % TB_CPS) == 0);
    endfunction

    task automatic model_reset();
        m_state  = 0;
        m_age    = 0;
        m_score  = 0;
        m_remain = TB_GS;
        m_res    = TB_RS;
        m_lfsr   = 16'hACE1;
        m_target = 3'd0;
        m_used   = 1'b0;
        m_kprev  = 8'h00;
    endtask

    task automatic model_step();
        bit         tk, hit, wrong, fb;
        logic [7:0] rise, want;
        logic [2:0] rnd;
        int         nst;
        exp_t       e;
        tk    = m_tick();
        rnd   = m_lfsr[2:0];
        rise  = bus.i_Key & ~m_kprev;
        want  = 8'h01 << m_target;
        nst   = m_state;
        hit   = (m_state == 1) && !m_used && (rise == want);
        wrong = (m_state == 1) && !m_used && (rise != 8'h00) && (rise != want);
        case (m_state)
            0: begin
                m_score  = 0;
                m_remain = TB_GS;
                if (bus.i_fStart) begin
                    nst      = 1;
                    m_target = rnd;
                    m_used   = 1'b0;
                end
            end
            1: begin
                if (hit) begin
                    m_score++;
                    m_used = 1'b1;
                end
                if (tk) begin
                    m_remain--;
                    m_target = rnd;
                    m_used   = 1'b0;
                end
                if (wrong) begin
                    nst = 3; m_res = TB_RS;
                end else if (hit && m_score == TB_HW) begin
                    nst = 2; m_res = TB_RS;
                end else if (tk && m_remain == 0) begin
                    nst = 3; m_res = TB_RS;
                end
            end
            default: begin
                if (tk) begin
                    m_res--;
                    if (m_res == 0) begin
                        nst      = 0;
                        m_score  = 0;
                        m_remain = TB_GS;
                    end
                end
            end
        endcase
        if (nst != m_state || nst == 0) m_age = 0;
        else m_age++;
        m_state = nst;
        fb      = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
        m_lfsr  = (m_lfsr >> 1) | (16'(fb) << 15);
        m_kprev = bus.i_Key;
        e.st  = 3'(m_state);
        e.tk  = m_tick();
        e.rnd = m_lfsr[3:0];
        e.rem = 8'(m_remain);
        e.sc  = 8'(m_score);
        q.push_back(e);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge i_Clk or negedge i_Rst);
            if (!i_Rst) begin
                model_reset();
                q.delete();
            end else begin
                model_step();
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge i_Clk);
            if (i_Rst && q.size() > 0) begin
                e = q.pop_front();
                chk("state",  int'(bus.o_State),      int'(e.st));
                chk("tick",   int'(bus.o_Sec1Tick),   int'(e.tk));
                chk("random", int'(bus.o_Random4Bit), int'(e.rnd));
                chk("remain", int'(bus.o_RemainSec),  int'(e.rem));
                chk("score",  int'(bus.o_Score),      int'(e.sc));
            end
        end
    end

    function automatic logic [7:0] oh(input logic [2:0] t);
        logic [7:0] one;
        one = 8'h01;
        return one << t;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge i_Clk);
    endtask

    task automatic start_game();
        bus.i_fStart = 1'b1;
        cyc(1);
        bus.i_fStart = 1'b0;
    endtask

    task automatic press(input logic [7:0] k);
        bus.i_Key = k;
        cyc(1);
        bus.i_Key = 8'h00;
        cyc(1);
    endtask

    task automatic wait_state(input int s, input int budget, input string name);
        int k;
        k = 0;
        while (int'(bus.o_State) != s && k < budget) begin
            cyc(1);
            k++;
        end
        chk(name, int'(bus.o_State), s);
    endtask

    task automatic wait_tick_cycle(input int budget, input string name);
        int k;
        k = 0;
        while (!m_tick() && k < budget) begin
            cyc(1);
            k++;
        end
        if (!m_tick()) chk(name, k, -1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_state"},  int'(bus.o_State),      0);
        chk({tag, "_tick"},   int'(bus.o_Sec1Tick),   0);
        chk({tag, "_random"}, int'(bus.o_Random4Bit), 1);
        chk({tag, "_remain"}, int'(bus.o_RemainSec),  TB_GS);
        chk({tag, "_score"},  int'(bus.o_Score),      0);
    endtask

    initial begin
        logic [2:0] t;
        int k;
        i_Rst        = 1'b0;
        bus.i_fStart = 1'b0;
        bus.i_Key    = 8'h00;
        cyc(3);
        check_reset_vals("por");
        #2 i_Rst = 1'b1;
        cyc(20);

        // two hits, one per second -> clear, then back to idle after two result seconds
        start_game();
        cyc(2);
        press(oh(m_target));
        wait_tick_cycle(20, "tick1_timeout");
        cyc(1);
        press(oh(m_target));
        wait_state(2, 4, "win_clear");
        wait_state(0, 40, "clear_to_idle");
        cyc(2);

        // wrong key, then target together with another key
        start_game();
        cyc(1);
        t = m_target + 3'd1;
        press(oh(t));
        wait_state(3, 4, "wrong_fail");
        wait_state(0, 40, "fail_to_idle");
        start_game();
        cyc(1);
        t = m_target + 3'd3;
        press(oh(m_target) | oh(t));
        wait_state(3, 4, "multi_fail");
        wait_state(0, 40, "fail_to_idle2");

        // double press within one second counts once; then run out the clock
        start_game();
        cyc(1);
        press(oh(m_target));
        press(oh(m_target));
        wait_state(3, 40, "timeout_fail");
        wait_state(0, 40, "timeout_to_idle");

        // winning hit on the final timeout tick
        start_game();
        wait_tick_cycle(20, "tick_wait_a");
        cyc(1);
        press(oh(m_target));
        k = 0;
        while (!(m_tick() && m_remain == 1) && k < 40) begin
            cyc(1);
            k++;
        end
        bus.i_Key = oh(m_target);
        cyc(1);
        bus.i_Key = 8'h00;
        wait_state(2, 3, "win_on_timeout");
        wait_state(0, 40, "win_to_idle");

        // wrong key on a tick cycle
        start_game();
        wait_tick_cycle(20, "tick_wait_b");
        t = m_target + 3'd5;
        bus.i_Key = oh(t);
        cyc(1);
        bus.i_Key = 8'h00;
        wait_state(3, 3, "wrong_on_tick");
        wait_state(0, 40, "wrong_tick_to_idle");

        // start pulses during play and during clear are ignored
        start_game();
        cyc(3);
        start_game();
        press(oh(m_target));
        wait_tick_cycle(20, "tick_wait_c");
        cyc(1);
        start_game();
        press(oh(m_target));
        wait_state(2, 4, "clear_again");
        cyc(5);
        start_game();
        wait_state(0, 40, "clear_again_idle");

        // asynchronous reset in the middle of a game
        start_game();
        cyc(12);
        #2 i_Rst = 1'b0;
        #1 check_reset_vals("midrst");
        cyc(2);
        #2 i_Rst = 1'b1;
        cyc(5);

        // randomized play
        repeat (300) begin
            case ($urandom_range(0, 9))
                0, 1:    start_game();
                2, 3, 4: press(oh(m_target));
                5: begin
                    t = m_target + 3'($urandom_range(1, 7));
                    press(oh(t));
                end
                6: begin
                    bus.i_Key = 8'($urandom_range(0, 255));
                    cyc($urandom_range(1, 3));
                    bus.i_Key = 8'h00;
                    cyc(1);
                end
                default: cyc($urandom_range(1, 6));
            endcase
        end

        cyc(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bomb_game_ctrl.md
# bomb_game_ctrl

Top-level sequencer for the bomb game. Owns the game state machine, the 1-second tick, the pseudo-random source and the per-game countdown and score. Drives the state, tick and random inputs of the LED driver, which lights one of eight LEDs. Judges player key presses against the LED currently lit and declares clear or fail.

## Interface
- P_CLK_PER_SEC, 50_000_000, i_Clk cycles per second tick (sim: 10)
- P_GAME_SEC, 30, game duration in seconds (1..255)
- P_HITS_TO_WIN, 10, correct hits required for clear (1..255)
- P_RESULT_SEC, 3, seconds CLEAR/FAIL is held before returning to IDLE (1..255)
- i_Clk  in  1  system clock, 50 MHz
- i_Rst  in  1  reset, asynchronous, active-low
- i_fStart  in  1  debounced start pulse (1 cycle)
- i_Key  in  8  debounced player keys, active-high level; bit n ↔ LED n
- o_State  out  3  game state (encoding below)
- o_Sec1Tick  out  1  one-cycle pulse per second while in GAME_START/CLEAR/FAIL
- o_Random4Bit  out  4  LFSR[3:0]
- o_RemainSec  out  8  seconds left in current game
- o_Score  out  8  correct hits this game

## Operation
- States: IDLE=3'b000, GAME_START=3'b001, GAME_CLEAR=3'b010, GAME_FAIL=3'b011; others unreachable, decode to IDLE.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1, shifts every cycle in all states, never zero.
- Target: 3-bit register, the LED currently lit. Loaded from o_Random4Bit[2:0] on (IDLE & i_fStart) and on (GAME_START & o_Sec1Tick). These are the same edges on which the LED driver latches, so target always equals the lit LED index. Loading clears `consumed`.
- Key edges: rise = i_Key & ~key_d (registered). Evaluated only in GAME_START.
  - rise == 0: nothing.
  - consumed = 1: all rises ignored until next target load.
  - rise == one-hot(target): hit; score+1, consumed=1.
  - any other nonzero rise (wrong key, or several keys together): go FAIL.
- IDLE: score=0, remain=P_GAME_SEC. i_fStart → GAME_START, tick counter cleared.
- GAME_START: each tick remain−1. Priority, highest first: wrong key → FAIL; hit making score == P_HITS_TO_WIN → CLEAR; tick with remain == 1 → FAIL (remain shows 0). i_fStart ignored.
- CLEAR/FAIL: result counter loaded with P_RESULT_SEC on entry, −1 per tick; tick at 1 → IDLE. Score/remain frozen. Keys and i_fStart ignored.
- Tick generator: counter 0..P_CLK_PER_SEC−1, pulse when count == max. Cleared to 0 on every state change and in IDLE (no tick in IDLE).

## Timing
- All outputs registered. Reset values: o_State=IDLE, o_Sec1Tick=0, o_Random4Bit=4'h1 (seed low nibble), o_RemainSec=P_GAME_SEC, o_Score=0. LFSR=16'hACE1, target=0, consumed=0, key_d=0.
- i_fStart at cycle N → o_State=GAME_START at N+1. First tick exactly P_CLK_PER_SEC cycles after entry.
- Key rise at edge N (i_Key high, key_d low) → score/state updated at N+1.
- Hit and tick same cycle: hit is scored against the old target, then target reloads. Winning hit with timeout tick in the same cycle → CLEAR.
- Wrong key and tick same cycle → FAIL; score is not incremented.
- Key held across a target load: no new edge, no action.
- Reset asserted mid-game: immediate asynchronous return to reset values; LFSR restarts from seed.

## Structure
- Package bomb_game_pkg: state localparams (shared with the LED driver), LFSR seed/taps, width constants.
- Sub-module sec_tick_gen (counter, sync clear input, tick output, parameter P_CLK_PER_SEC). LFSR, edge detector and FSM stay inline.

## Test plan
Sim params: P_CLK_PER_SEC=10, P_GAME_SEC=3, P_HITS_TO_WIN=2, P_RESULT_SEC=2.
- Reset, 20 idle cycles → o_State=0, no ticks, o_Score=0, o_RemainSec=3, LFSR sequence matches reference model from 16'hACE1.
- i_fStart, then press one-hot(target) after the start and again after the first tick → o_Score 1 then 2, o_State=2 one cycle after second hit; 2 ticks later o_State=0.
- Start, press a non-target key → o_State=3 next cycle; press two keys, one being target → FAIL.
- Start, press target twice within one second → o_Score=1 only; no ticks with keys → ticks at 10/20/30 cycles, remain 2/1/0, FAIL at third tick.
- Winning hit on the same cycle as final timeout tick → CLEAR; wrong key on a tick cycle → FAIL, score unchanged.
- Assert i_Rst mid-GAME_START → all outputs at reset values asynchronously; i_fStart during GAME_START/CLEAR ignored.
